// File: rtl/set_bit_seq_pkg.sv
// Shared types and helpers for the set-bit sequencer.
// Optional feature macro: SET_BIT_SEQ_EMPTY_PASS_EN (adds the EMPTY state).
package set_bit_seq_pkg;

  // Widest mask the clear-lowest helper handles; callers zero-extend into it.
  localparam int MAX_W = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1
`ifdef SET_BIT_SEQ_EMPTY_PASS_EN
    ,
    ST_EMPTY = 2'd2
`endif
  } state_t;

  // Index width: enough bits to also represent DATA_WIDTH itself (empty mask).
  function automatic int idx_w(input int width);
    return $clog2(width) + 1;
  endfunction

  // Clears the lowest set bit of v.
  function automatic logic [MAX_W-1:0] clear_lowest_set(input logic [MAX_W-1:0] v);
    return v & (v - 1'b1);
  endfunction

endpackage

// File: rtl/set_bit_sequencer_trailing_zero_count.sv
// Combinational trailing-zero count; an all-zero input returns DATA_WIDTH.
module trailing_zero_count
  import set_bit_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]        din,
  output logic [idx_w(DATA_WIDTH)-1:0] count
);

  localparam int IDX_W = idx_w(DATA_WIDTH);

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    count = IDX_W'(DATA_WIDTH);
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (din[i]) count = IDX_W'(i);
    end
  end

endmodule

// File: rtl/set_bit_sequencer.sv
// Drains a request mask one set bit per cycle, lowest index first, over a
// valid/ready stream. Back-to-back masks are accepted on the last beat.
// Optional feature macro: SET_BIT_SEQ_EMPTY_PASS_EN (all-zero masks emit one
// beat with dout=DATA_WIDTH instead of being swallowed).
module set_bit_sequencer
  import set_bit_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         din_valid,
  output logic                         din_ready,
  input  logic [DATA_WIDTH-1:0]        din,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic [idx_w(DATA_WIDTH)-1:0] dout,
  output logic                         dout_last,
  output logic                         busy
);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic                  din_hs, dout_hs;

  trailing_zero_count #(.DATA_WIDTH(DATA_WIDTH)) u_tzc (
    .din   (mask_q),
    .count (dout)
  );

  // State and mask registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

  // Handshakes, stream outputs and next-state selection.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    dout_valid = (state_q != ST_IDLE);
    busy       = (state_q != ST_IDLE);
    // In EMPTY mask_q is zero, so this also flags the single empty beat as last.
    dout_last  = dout_valid && ((mask_q & (mask_q - 1'b1)) == '0);
    din_ready  = (state_q == ST_IDLE) || (dout_ready && dout_last);
    din_hs     = din_valid && din_ready;
    dout_hs    = dout_valid && dout_ready;

    if (dout_hs) begin
      if (dout_last) begin
        state_d = ST_IDLE;
        mask_d  = '0;
      end else begin
        mask_d = DATA_WIDTH'(clear_lowest_set(MAX_W'(mask_q)));
      end
    end

    // A new mask can only land when idle or on the final beat of the current one.
    if (din_hs) begin
      if (din != '0) begin
        mask_d  = din;
        state_d = ST_DRAIN;
      end
`ifdef SET_BIT_SEQ_EMPTY_PASS_EN
      else begin
        mask_d  = '0;
        state_d = ST_EMPTY;
      end
`endif
    end
  end

endmodule

// File: tb/tb_set_bit_sequencer.sv
// Self-checking bench for set_bit_sequencer (DATA_WIDTH=32).
// Honours SET_BIT_SEQ_EMPTY_PASS_EN in the same way as the design.
module tb_set_bit_sequencer;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [W-1:0] din = '0;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic [5:0]  dout;
  logic        dout_last;
  logic        busy;

  set_bit_sequencer #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din        (din),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_last  (dout_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit armed = 0;

  // Reference: queue of indices still to be emitted, in emission order.
  int q[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input logic v, input logic [W-1:0] d, input logic r, input logic rst);
    din_valid  = v;
    din        = d;
    dout_ready = r;
    reset      = rst;
    #3;
  endtask

  task automatic model_check();
    int n;
    n = q.size();
    if (!armed) return;
    chk("m_valid", dout_valid, (n > 0) ? 1 : 0);
    chk("m_busy", busy, (n > 0) ? 1 : 0);
    chk("m_dout", dout, (n > 0) ? q[0] : W);
    chk("m_last", dout_last, (n == 1) ? 1 : 0);
    chk("m_ready", din_ready, (n == 0 || (dout_ready && n == 1)) ? 1 : 0);
  endtask

  // Advance one clock and update the model from the inputs held this cycle.
  task automatic advance();
    int  n;
    bit  dhs, ihs;
    logic [W-1:0] d;
    n   = q.size();
    d   = din;
    dhs = (n > 0) && dout_ready;
    ihs = din_valid && (n == 0 || (dout_ready && n == 1));
    @(posedge clk);
    #1;
    if (reset) begin
      q.delete();
    end else begin
      if (dhs) void'(q.pop_front());
      if (ihs) begin
        if (d != '0) begin
          for (int i = 0; i < W; i++) if (d[i]) q.push_back(i);
        end
`ifdef SET_BIT_SEQ_EMPTY_PASS_EN
        else q.push_back(W);
`endif
      end
    end
  endtask

  task automatic cycle(input logic v, input logic [W-1:0] d, input logic r, input logic rst);
    apply(v, d, r, rst);
    model_check();
    advance();
  endtask

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         r;
    logic         ev;
    int           edout;
    logic         elast;
    logic         erdy;
  } vec_t;

  vec_t tab[18];

  initial begin
    logic [W-1:0] rd;

    // full drain: 0,2,4,31
    tab[0]  = '{1'b1, 32'h8000_0015, 1'b1, 1'b0, 32, 1'b0, 1'b1};
    tab[1]  = '{1'b0, 32'h0,         1'b1, 1'b1, 0,  1'b0, 1'b0};
    tab[2]  = '{1'b0, 32'h0,         1'b1, 1'b1, 2,  1'b0, 1'b0};
    tab[3]  = '{1'b0, 32'h0,         1'b1, 1'b1, 4,  1'b0, 1'b0};
    tab[4]  = '{1'b0, 32'h0,         1'b1, 1'b1, 31, 1'b1, 1'b1};
    tab[5]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32, 1'b0, 1'b1};
    // backpressure: 8 held three cycles, then 8, 9
    tab[6]  = '{1'b1, 32'h0000_0300, 1'b0, 1'b0, 32, 1'b0, 1'b1};
    tab[7]  = '{1'b0, 32'h0,         1'b0, 1'b1, 8,  1'b0, 1'b0};
    tab[8]  = '{1'b0, 32'h0,         1'b0, 1'b1, 8,  1'b0, 1'b0};
    tab[9]  = '{1'b0, 32'h0,         1'b0, 1'b1, 8,  1'b0, 1'b0};
    tab[10] = '{1'b0, 32'h0,         1'b1, 1'b1, 8,  1'b0, 1'b0};
    tab[11] = '{1'b0, 32'h0,         1'b1, 1'b1, 9,  1'b1, 1'b1};
    tab[12] = '{1'b0, 32'h0,         1'b1, 1'b0, 32, 1'b0, 1'b1};
    // back-to-back: 0(last) then 1, 2(last) with no gap
    tab[13] = '{1'b1, 32'h1,         1'b1, 1'b0, 32, 1'b0, 1'b1};
    tab[14] = '{1'b1, 32'h6,         1'b1, 1'b1, 0,  1'b1, 1'b1};
    tab[15] = '{1'b1, 32'h6,         1'b1, 1'b1, 1,  1'b0, 1'b0};
    tab[16] = '{1'b0, 32'h0,         1'b1, 1'b1, 2,  1'b1, 1'b1};
    tab[17] = '{1'b0, 32'h0,         1'b1, 1'b0, 32, 1'b0, 1'b1};

    // reset, then check the reset state explicitly
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    armed = 1;
    apply(1'b0, '0, 1'b0, 1'b0);
    chk("rst_din_ready", din_ready, 1);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout", dout, W);
    chk("rst_dout_last", dout_last, 0);
    chk("rst_busy", busy, 0);
    model_check();
    advance();

    for (int i = 0; i < 18; i++) begin
      apply(tab[i].v, tab[i].d, tab[i].r, 1'b0);
      chk($sformatf("tab%0d_valid", i), dout_valid, tab[i].ev);
      chk($sformatf("tab%0d_dout", i), dout, tab[i].edout);
      chk($sformatf("tab%0d_last", i), dout_last, tab[i].elast);
      chk($sformatf("tab%0d_ready", i), din_ready, tab[i].erdy);
      model_check();
      advance();
    end

    // zero mask
    apply(1'b1, '0, 1'b1, 1'b0);
    chk("zero_accept_ready", din_ready, 1);
    advance();
    apply(1'b0, '0, 1'b1, 1'b0);
`ifdef SET_BIT_SEQ_EMPTY_PASS_EN
    chk("zero_valid", dout_valid, 1);
    chk("zero_dout", dout, W);
    chk("zero_last", dout_last, 1);
`else
    chk("zero_valid", dout_valid, 0);
    chk("zero_ready", din_ready, 1);
`endif
    model_check();
    advance();
    cycle(1'b0, '0, 1'b1, 1'b0);

    // reset mid-drain of an all-ones mask after five beats
    cycle(1'b1, '1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, '0, 1'b1, 1'b0);
      chk($sformatf("ones_beat%0d", i), dout, i);
      model_check();
      advance();
    end
    apply(1'b0, '0, 1'b0, 1'b1);
    chk("ones_beat5_presented", dout, 5);
    model_check();
    advance();
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, '0, 1'b1, 1'b0);
      chk($sformatf("post_rst_valid%0d", i), dout_valid, 0);
      model_check();
      advance();
    end

    // randomized traffic against the queue model
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 5))
        0: rd = $urandom;
        1: rd = 32'h1 << $urandom_range(0, 31);
        2: rd = '0;
        3: rd = '1;
        4: rd = $urandom & $urandom & $urandom;
        default: rd = 32'h8000_0000;
      endcase
      cycle($urandom_range(0, 2) == 0, rd, $urandom_range(0, 9) < 7,
            $urandom_range(0, 199) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/set_bit_sequencer.md
# set_bit_sequencer

Drains a DATA_WIDTH-bit request mask one set bit per cycle, lowest index first, and emits each bit index over a valid/ready stream. It sits between a producer of pending-request vectors (interrupt, completion or dirty-line masks) and a consumer that services one index at a time. Index selection uses a trailing-zero count of the remaining mask. An accepted set bit is cleared only when its index is handed off.

## Interface
- DATA_WIDTH, 32, width of the request mask (≥2)
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- din_valid  in  1  producer offers a mask
- din_ready  out  1  block can accept a mask this cycle
- din  in  DATA_WIDTH  request mask
- dout_valid  out  1  dout holds a valid index
- dout_ready  in  1  consumer accepts dout this cycle
- dout  out  $clog2(DATA_WIDTH)+1  bit index (trailing-zero count of the remaining mask)
- dout_last  out  1  current beat is the final beat of this mask
- busy  out  1  a mask is being drained (state ≠ IDLE)

## Operation
- Registers: state (IDLE, DRAIN, plus EMPTY when configured) and mask_q [DATA_WIDTH-1:0].
- dout is the combinational trailing-zero count of mask_q. When mask_q==0, dout = DATA_WIDTH.
- dout_last = dout_valid && (mask_q & (mask_q-1))==0.
- IDLE:
  - din_ready=1 and dout_valid=0.
  - On a din handshake with nonzero din: mask_q<=din and state→DRAIN.
- DRAIN:
  - dout_valid=1.
  - On a dout handshake that is not last: mask_q<=mask_q & (mask_q-1) (clears the lowest set bit).
  - On a dout handshake with dout_last=1: mask_q<=0 and state→IDLE.
- Back-to-back masks:
  - In DRAIN, din_ready = dout_valid && dout_ready && dout_last.
  - A din handshake in that same cycle loads the new din into mask_q. State stays DRAIN if the new din is nonzero; otherwise the zero-mask rule applies.
  - dout_valid is not deasserted between consecutive masks.
- dout and dout_last hold stable while dout_valid=1 and dout_ready=0.
- din is ignored when din_ready=0.
- Number of beats per mask = popcount(din). Indices are strictly increasing within a mask.

## Timing
- Reset values: state=IDLE, mask_q=0, din_ready=1, dout_valid=0, dout=DATA_WIDTH, dout_last=0, busy=0.
- Reset overrides any handshake in the same cycle. A mask being drained when reset asserts is discarded, and no further beats are emitted.
- Latency: a mask accepted at edge N gives its first dout_valid in the cycle after N (1 cycle).
- Throughput: one index per cycle while dout_ready=1, with zero bubbles across consecutive masks.
- A mask with only bit DATA_WIDTH-1 set produces one beat with dout=DATA_WIDTH-1 and dout_last=1.
- An all-ones mask produces DATA_WIDTH beats, indices 0..DATA_WIDTH-1.

## Configuration
- SET_BIT_SEQ_EMPTY_PASS_EN defined:
  - An accepted all-zero mask enters state EMPTY for one beat: dout_valid=1, dout=DATA_WIDTH, dout_last=1.
  - On the handshake, state→IDLE, or directly to the next mask if back-to-back din is accepted.
  - din_ready in EMPTY follows the DRAIN rule.
- Not defined:
  - An accepted all-zero mask is consumed silently and the state does not change.
  - No beat is emitted and the EMPTY state does not exist.

## Structure
- Package set_bit_seq_pkg holds:
  - the state enum;
  - localparam IDX_W = $clog2(DATA_WIDTH)+1, supplied as a function parameterised by width;
  - a clear-lowest-set-bit helper function.
- Sub-module trailing_zero_count: purely combinational, parameter DATA_WIDTH, input din, output count[IDX_W-1:0]. An all-zero input returns DATA_WIDTH. It is instantiated once on mask_q.

## Test plan
- Reset then idle: after reset, outputs are din_ready=1, dout_valid=0, dout=32, busy=0.
- Full drain: din=32'h8000_0015 with dout_ready=1 → beats 0, 2, 4, 31 on consecutive cycles; dout_last only on 31; busy drops the next cycle.
- Backpressure: din=32'h0000_0300 with dout_ready low for 3 cycles → dout=8 held stable for 3 cycles, then beats 8 and 9 after dout_ready rises.
- Back-to-back masks: din=32'h1 then din=32'h6 offered continuously → beats 0(last), 1, 2(last) with no idle cycle; the second mask is accepted on the edge of the 0(last) handshake.
- Zero mask: din=0 → with SET_BIT_SEQ_EMPTY_PASS_EN, one beat dout=32 with dout_last=1; without it, no beat and din_ready stays 1.
- Reset mid-drain: din=32'hFFFF_FFFF, reset asserted after 5 beats → dout_valid=0 the next cycle, and no beat 5 is ever emitted.
